// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch producer.
// Generates the fetch PC and runs a single-outstanding request/ack handshake
// with instruction memory. Fetched words go into a small prefetch FIFO whose
// head drives the IF/ID register. A branch redirect flushes everything and
// restarts fetching at the target.
// Optional feature macro: IF_BYPASS_EN. When it is defined, an acked word that
// arrives while the FIFO is empty is presented on the outputs in the same cycle.
//
// Handshake: imem_req/imem_addr come straight from registers. Once raised,
// they stay stable until the cycle in which imem_ack is high; a transfer
// completes on the rising edge where imem_req && imem_ack. imem_rdata is only
// meaningful in that cycle.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        flush_out,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_ISSUE   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [31:0]   fifo_pc  [FIFO_DEPTH];
  logic [31:0]   fifo_ins [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          flush_q;

  logic          empty, full;
  logic          ack_ok;
  logic          bypass;
  logic          push, pop;
  logic [31:0]   pc_plus4;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign ack_ok   = (state == S_WAIT) && imem_ack;
  assign pc_plus4 = fetch_pc + 32'd4;

`ifdef IF_BYPASS_EN
  // Word lands on an empty FIFO: show it this cycle instead of waiting for the push.
  assign bypass = ack_ok && empty && !branch_taken;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is consumed immediately never needs a FIFO slot.
  assign push = ack_ok && !branch_taken && !(bypass && !freeze);
  assign pop  = !empty && !freeze && !branch_taken;

  assign imem_req  = (state != S_ISSUE);
  assign imem_addr = req_addr;
  assign flush_out = flush_q;
  assign state_dbg = state;

  // Output view: bypass word first, else FIFO head, else a zero bubble.
  always_comb begin
    fetch_valid     = 1'b0;
    pc_out          = 32'h0;
    instruction_out = 32'h0;
    if (bypass) begin
      fetch_valid     = 1'b1;
      pc_out          = pc_plus4;
      instruction_out = imem_rdata;
    end else if (!empty) begin
      fetch_valid     = 1'b1;
      pc_out          = fifo_pc[rd_ptr];
      instruction_out = fifo_ins[rd_ptr];
    end
  end

  // Next-state logic; a redirect while a request is in flight must still wait for its ack.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ISSUE:   if (branch_taken || !full) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_ack)          state_nxt = S_ISSUE;
        else if (branch_taken) state_nxt = S_DISCARD;
      end
      S_DISCARD: if (imem_ack) state_nxt = S_ISSUE;
      default:   state_nxt = S_ISSUE;
    endcase
  end

  // State register, PC, latched request address, FIFO pointers/count and flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ISSUE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      flush_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      flush_q <= branch_taken;
      if (state == S_ISSUE && state_nxt == S_WAIT)
        req_addr <= branch_taken ? branch_addr : fetch_pc;
      if (branch_taken) begin
        fetch_pc <= branch_addr;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (ack_ok) fetch_pc <= pc_plus4;
        if (push)   wr_ptr   <= wr_ptr + AW'(1);
        if (pop)    rd_ptr   <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !push) count <= count - (AW+1)'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]  <= pc_plus4;
      fifo_ins[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios with hand-computed expectations.
// Two instances share clock, reset, freeze and branch inputs: dut (RESET_PC=0)
// and dut_w (RESET_PC=32'hFFFFFFF8, zero-wait memory) for the PC wrap case.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;

  logic        imem_req, imem_ack, fetch_valid, flush_out;
  logic [31:0] imem_addr, imem_rdata, pc_out, instruction_out;
  logic [1:0]  state_dbg;

  logic        w_imem_req, w_imem_ack, w_fetch_valid, w_flush_out;
  logic [31:0] w_imem_addr, w_imem_rdata, w_pc_out, w_instruction_out;
  logic [1:0]  w_state_dbg;

  int          checks = 0;
  int          failures = 0;
  int          mem_lat = 1;
  logic        ack_hold = 1'b0;
  int          wcnt;

  logic [31:0] exp_q[$];
  logic [31:0] iss_q[$], pop_q[$], pop_i_q[$];
  logic [31:0] w_iss_q[$], w_pop_q[$], w_pop_i_q[$];
  logic        req_prev = 1'b0, w_req_prev = 1'b0;
  logic        seen;

  // clock / reset
  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
    .pc_out(pc_out), .instruction_out(instruction_out), .flush_out(flush_out),
    .state_dbg(state_dbg)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFFFFF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .fetch_valid(w_fetch_valid),
    .pc_out(w_pc_out), .instruction_out(w_instruction_out), .flush_out(w_flush_out),
    .state_dbg(w_state_dbg)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD0000;
  endfunction

  // memory model: ack after mem_lat waiting cycles, unless held off
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wcnt <= 0;
    else if (imem_req && imem_ack) wcnt <= 0;
    else if (imem_req)             wcnt <= wcnt + 1;
  end
  assign imem_ack     = imem_req && !ack_hold && (wcnt >= mem_lat);
  assign imem_rdata   = imem_ack ? instr_of(imem_addr) : 32'h0;
  assign w_imem_ack   = w_imem_req;
  assign w_imem_rdata = w_imem_ack ? instr_of(w_imem_addr) : 32'h0;

  // monitors: issued addresses (rising req) and consumed output entries
  always @(negedge clk) begin
    if (imem_req && !req_prev)     iss_q.push_back(imem_addr);
    if (w_imem_req && !w_req_prev) w_iss_q.push_back(w_imem_addr);
    req_prev   <= imem_req;
    w_req_prev <= w_imem_req;
    if (fetch_valid && !freeze && !branch_taken) begin
      pop_q.push_back(pc_out);
      pop_i_q.push_back(instruction_out);
    end
    if (w_fetch_valid && !freeze && !branch_taken) begin
      w_pop_q.push_back(w_pc_out);
      w_pop_i_q.push_back(w_instruction_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: compare a logged sequence against exp_q, then empty exp_q
  task automatic check_log(input string tag, input logic [31:0] got_q[$]);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < got_q.size()) ? got_q[i] : 32'hBAD0BAD0, exp_q[i]);
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_q.delete(); pop_q.delete(); pop_i_q.delete();
    w_iss_q.delete(); w_pop_q.delete(); w_pop_i_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    clear_logs();
    rst_n = 1'b1;
  endtask

  // wait (bounded) until a request is outstanding and not yet acked
  task automatic wait_req(input string tag);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (imem_req && !imem_ack) seen = 1'b1;
      else tick();
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    // 1: reset values, then sequential fetch with 1-cycle memory
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instruction_out, 32'h0);
    check("rst_flush", flush_out, 1'b0);
    check("rst_w_addr", w_imem_addr, 32'hFFFFFFF8);
    repeat (3) begin
      tick();
      check("rst_valid", fetch_valid, 1'b0);
      check("rst_req_hold", imem_req, 1'b0);
    end
    clear_logs();
    rst_n = 1'b1;
    tick();
    check("t1_first_req", imem_req, 1'b1);
    repeat (20) tick();
    exp_q = '{32'h0, 32'h4, 32'h8};
    check_log("t1_iss", iss_q);
    exp_q = '{32'h4, 32'h8, 32'hC};
    check_log("t1_pc", pop_q);
    exp_q = '{32'hDEAD0000, 32'hDEAD0004, 32'hDEAD0008};
    check_log("t1_ins", pop_i_q);

    // 5: PC wrap on the RESET_PC=FFFFFFF8 instance (ran alongside test 1)
    exp_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0};
    check_log("t5_iss", w_iss_q);
    exp_q = '{32'hFFFFFFFC, 32'h0, 32'h4};
    check_log("t5_pc", w_pop_q);
    exp_q = '{32'h2152FFF8, 32'h2152FFFC, 32'hDEAD0000};
    check_log("t5_ins", w_pop_i_q);

    // 2: freeze with zero-wait memory fills FIFO, then release resumes cleanly
    freeze  = 1'b1;
    mem_lat = 0;
    do_reset(2);
    repeat (4) tick();
    repeat (5) begin
      tick();
      check("t2_req_off", imem_req, 1'b0);
      check("t2_valid", fetch_valid, 1'b1);
      check("t2_pc_hold", pc_out, 32'h4);
      check("t2_ins_hold", instruction_out, 32'hDEAD0000);
    end
    clear_logs();
    freeze = 1'b0;
    repeat (25) tick();
    exp_q = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
    check_log("t2_pc", pop_q);

    // 3: redirect while waiting on a slow response
    mem_lat = 3;
    do_reset(2);
    wait_req("t3_req_seen");
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();
    branch_taken = 1'b0;
    check("t3_flush_on", flush_out, 1'b1);
    check("t3_req_held", imem_req, 1'b1);
    check("t3_addr_held", imem_addr, 32'h0);
    tick();
    check("t3_flush_off", flush_out, 1'b0);
    repeat (20) tick();
    exp_q = '{32'h0, 32'h100};
    check_log("t3_iss", iss_q);
    exp_q = '{32'h104, 32'h108};
    check_log("t3_pc", pop_q);
    exp_q = '{32'hDEAD0100};
    check_log("t3_ins", pop_i_q);

    // 4: redirect in the same cycle as ack, under freeze
    freeze   = 1'b1;
    ack_hold = 1'b1;
    mem_lat  = 0;
    do_reset(2);
    wait_req("t4_req_seen");
    ack_hold     = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    #1;
    check("t4_ack_cycle_valid", fetch_valid, 1'b0);
    tick();
    branch_taken = 1'b0;
    check("t4_flush", flush_out, 1'b1);
    check("t4_empty", fetch_valid, 1'b0);
    repeat (6) tick();
    check("t4_valid", fetch_valid, 1'b1);
    check("t4_pc", pc_out, 32'h204);
    check("t4_ins", instruction_out, 32'hDEAD0200);
    exp_q = '{32'h0, 32'h200};
    check_log("t4_iss", iss_q);

    // 6: asynchronous reset in the middle of a wait
    freeze  = 1'b1;
    mem_lat = 3;
    do_reset(2);
    repeat (7) tick();
    wait_req("t6_req_seen");
    check("t6_pre_valid", fetch_valid, 1'b1);
    check("t6_pre_pc", pc_out, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", fetch_valid, 1'b0);
    check("t6_async_pc", pc_out, 32'h0);
    check("t6_async_ins", instruction_out, 32'h0);
    check("t6_async_req", imem_req, 1'b0);
    check("t6_async_addr", imem_addr, 32'h0);
    mem_lat = 0;
    freeze  = 1'b0;
    tick();
    clear_logs();
    rst_n = 1'b1;
    tick();
    check("t6_req", imem_req, 1'b1);
    check("t6_addr", imem_addr, 32'h0);
`ifdef IF_BYPASS_EN
    check("t6_byp_valid", fetch_valid, 1'b1);
    check("t6_byp_pc", pc_out, 32'h4);
    check("t6_byp_ins", instruction_out, 32'hDEAD0000);
`else
    check("t6_nobyp_valid", fetch_valid, 1'b0);
    check("t6_nobyp_pc", pc_out, 32'h0);
    tick();
    check("t6_push_valid", fetch_valid, 1'b1);
    check("t6_push_pc", pc_out, 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
